// File: rtl/pwm_pkg.sv
// Shared widths, FSM encoding and helpers for the PWM duty-cycle front-end.
package pwm_pkg;

  localparam int PWM_W      = 16;
  localparam int PCT_W      = 8;
  localparam int PROD_W     = 23;
  localparam int PCT_MAX    = 100;
  localparam int MUL_CYCLES = PCT_W;
  localparam int DIV_CYCLES = PROD_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [PCT_W-1:0] clamp_pct(input logic [PCT_W-1:0] pct);
    return (pct > PCT_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : pct;
  endfunction

endpackage

// File: rtl/pwm_duty_calc_if.sv
// Command handshake bundle feeding the duty-cycle calculator.
interface pwm_duty_calc_if;
  import pwm_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [PWM_W-1:0] cmd_period;
  logic [PCT_W-1:0] cmd_percent;

  modport master (output cmd_valid, output cmd_period, output cmd_percent, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_period, input cmd_percent, output cmd_ready);

endinterface

// File: rtl/pwm_serial_div.sv
// Restoring divider of a PROD_W-bit dividend by a small constant, one quotient
// bit per clock; the start cycle already processes the first bit.
module pwm_serial_div
  import pwm_pkg::*;
#(
  parameter int DIVISOR = PCT_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] dividend,
  output logic [PWM_W-1:0]  quotient,
  output logic              done
);

  localparam int REM_W = $clog2(DIVISOR);

  logic [PROD_W-1:0] work_reg;
  logic [PROD_W-1:0] work_src;
  logic [PROD_W-1:0] work_next;
  logic [REM_W-1:0]  rem_reg;
  logic [REM_W-1:0]  rem_src;
  logic [REM_W-1:0]  rem_next;
  logic [REM_W:0]    rem_sh;
  logic              q_bit;
  logic [4:0]        cnt_reg;
  logic              active_reg;
  logic              done_reg;

  // Dividend bits shift out of the top of work_reg while quotient bits fill in below.
  always_comb begin
    work_src  = start ? dividend : work_reg;
    rem_src   = start ? '0 : rem_reg;
    rem_sh    = {rem_src, work_src[PROD_W-1]};
    q_bit     = (rem_sh >= (REM_W+1)'(DIVISOR));
    rem_next  = q_bit ? REM_W'(rem_sh - (REM_W+1)'(DIVISOR)) : rem_sh[REM_W-1:0];
    work_next = {work_src[PROD_W-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg   <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start || active_reg) begin
        work_reg <= work_next;
        rem_reg  <= rem_next;
      end
      if (start) begin
        active_reg <= 1'b1;
        cnt_reg    <= 5'd1;
      end else if (active_reg) begin
        cnt_reg <= cnt_reg + 5'd1;
        if (cnt_reg == 5'(PROD_W - 1)) begin
          active_reg <= 1'b0;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  // The quotient never exceeds 16 bits because the dividend is at most 65535*100.
  assign quotient = work_reg[PWM_W-1:0];
  assign done     = done_reg;

endmodule

// File: rtl/pwm_duty_calc.sv
// Computes duty_cycle = floor(period*percent/100) with serial mul/div and drives
// the PWM generator registers. Define PWM_DUTY_RAMP_EN for stepped duty ramping.
module pwm_duty_calc
  import pwm_pkg::*;
#(
  parameter logic [PWM_W-1:0] RESET_PERIOD = 16'd1000,
  parameter int               RAMP_DIV     = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pwm_duty_calc_if.slave         cmd,
  output logic [PWM_W-1:0]       duty_cycle,
  output logic [PWM_W-1:0]       period_out,
  output logic                   upd_pulse,
  output logic                   busy,
  output logic                   settled
);

  if (RAMP_DIV < 1) begin : g_ramp_div_chk
    $error("RAMP_DIV must be at least 1");
  end

  state_t            state_reg;
  state_t            state_next;
  logic [4:0]        cnt_reg;
  logic [4:0]        cnt_next;
  logic              accept;
  logic              div_start;
  logic              div_done;
  logic [PWM_W-1:0]  quotient;
  logic              load;

  logic [PWM_W-1:0]  period_reg;
  logic [PCT_W-1:0]  pct_reg;
  logic [PROD_W-1:0] mcand_reg;
  logic [PROD_W-1:0] prod_reg;

  logic [PWM_W-1:0]  duty_reg;
  logic [PWM_W-1:0]  period_out_reg;
  logic              upd_reg;
  logic              busy_reg;
  logic              ready_reg;

  assign accept = cmd.cmd_valid && ready_reg;
  assign load   = div_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_start  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_MUL;
          cnt_next   = '0;
        end
      end
      S_MUL: begin
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'(MUL_CYCLES - 1)) begin
          state_next = S_DIV;
          cnt_next   = '0;
        end
      end
      S_DIV: begin
        div_start = (cnt_reg == 5'd0);
        cnt_next  = cnt_reg + 5'd1;
        if (cnt_reg == 5'(DIV_CYCLES - 1)) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Shift-add multiplier: one percent bit per MUL cycle, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg <= '0;
      pct_reg    <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
    end else if (accept) begin
      period_reg <= cmd.cmd_period;
      pct_reg    <= clamp_pct(cmd.cmd_percent);
      mcand_reg  <= {{(PROD_W-PWM_W){1'b0}}, cmd.cmd_period};
      prod_reg   <= '0;
    end else if (state_reg == S_MUL) begin
      if (pct_reg[0]) begin
        prod_reg <= prod_reg + mcand_reg;
      end
      mcand_reg <= mcand_reg << 1;
      pct_reg   <= pct_reg >> 1;
    end
  end

  pwm_serial_div #(
    .DIVISOR (PCT_MAX)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (prod_reg),
    .quotient (quotient),
    .done     (div_done)
  );

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_out_reg <= RESET_PERIOD;
      upd_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      upd_reg   <= load;
      busy_reg  <= (state_next != S_IDLE);
      ready_reg <= (state_next == S_IDLE);
      if (load) begin
        period_out_reg <= period_reg;
      end
    end
  end

`ifdef PWM_DUTY_RAMP_EN
  localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PS_W-1:0]  ps_reg;
  logic             tick;
  logic [PWM_W-1:0] target_reg;
  logic [PWM_W-1:0] target_next;
  logic [PWM_W-1:0] duty_base;
  logic [PWM_W-1:0] duty_next;
  logic             settled_reg;

  assign tick = (ps_reg == PS_W'(RAMP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_reg <= '0;
    end else if (tick) begin
      ps_reg <= '0;
    end else begin
      ps_reg <= ps_reg + PS_W'(1);
    end
  end

  // A new command clamps the duty to the new period, then the tick still applies.
  always_comb begin
    target_next = load ? quotient : target_reg;
    duty_base   = (load && (duty_reg > period_reg)) ? period_reg : duty_reg;
    duty_next   = duty_base;
    if (tick) begin
      if (duty_base < target_next) begin
        duty_next = duty_base + 16'd1;
      end else if (duty_base > target_next) begin
        duty_next = duty_base - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_reg    <= '0;
      target_reg  <= '0;
      settled_reg <= 1'b1;
    end else begin
      duty_reg    <= duty_next;
      target_reg  <= target_next;
      settled_reg <= (duty_next == target_next);
    end
  end

  assign settled = settled_reg;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_reg <= '0;
    end else if (load) begin
      duty_reg <= quotient;
    end
  end

  assign settled = 1'b1;
`endif

  assign duty_cycle    = duty_reg;
  assign period_out    = period_out_reg;
  assign upd_pulse     = upd_reg;
  assign busy          = busy_reg;
  assign cmd.cmd_ready = ready_reg;

  assert property (@(posedge clk) disable iff (!rst_n) upd_reg |=> !upd_reg);
  assert property (@(posedge clk) disable iff (!rst_n) ready_reg |-> !busy_reg);
  assert property (@(posedge clk) disable iff (!rst_n) div_done |-> (state_reg == S_DONE));

endmodule

// File: tb/tb_pwm_duty_calc.sv
// Scoreboard bench for pwm_duty_calc: driver queues expected results, a monitor
// checks them on every upd_pulse. Ramp scenario runs when PWM_DUTY_RAMP_EN is set.
module tb_pwm_duty_calc;
  import pwm_pkg::*;

`ifdef PWM_DUTY_RAMP_EN
  localparam int RDIV = 4;
`else
  localparam int RDIV = 256;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] duty_cycle;
  logic [15:0] period_out;
  logic        upd_pulse;
  logic        busy;
  logic        settled;

  pwm_duty_calc_if cmd ();

  pwm_duty_calc #(
    .RESET_PERIOD (16'd1000),
    .RAMP_DIV     (RDIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .duty_cycle (duty_cycle),
    .period_out (period_out),
    .upd_pulse  (upd_pulse),
    .busy       (busy),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] duty;
    logic [15:0] period;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur_target = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every update strobe must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && upd_pulse === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_upd", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("upd_latency", cyc, e.due);
`ifndef PWM_DUTY_RAMP_EN
          check("duty_cycle", duty_cycle, e.duty);
`endif
          check("period_out", period_out, e.period);
          cur_target = int'(e.duty);
          $display("upd: period=%0d duty=%0d expected duty=%0d", period_out, duty_cycle, e.duty);
        end
      end
    end
  end

  task automatic send(input logic [15:0] per, input logic [7:0] pct,
                      input logic [15:0] exp_duty, input bit expect_result);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cmd.cmd_ready !== 1'b1) begin
      check("ready_timeout", 0, 1);
      return;
    end
    cmd.cmd_valid   = 1'b1;
    cmd.cmd_period  = per;
    cmd.cmd_percent = pct;
    @(posedge clk);
    #1;
    if (expect_result) sb_q.push_back('{duty: exp_duty, period: per, due: cyc + 32});
    $display("cmd: period=%0d percent=%0d expect duty=%0d", per, pct, exp_duty);
    cmd.cmd_valid   = 1'b0;
    cmd.cmd_period  = 16'($urandom);
    cmd.cmd_percent = 8'($urandom);
    @(negedge clk);
    check("ready_low_when_busy", cmd.cmd_ready, 0);
    check("busy_high", busy, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || cmd.cmd_ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_reached", (sb_q.size() == 0 && cmd.cmd_ready === 1'b1) ? 1 : 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_duty"}, duty_cycle, 0);
    check({tag, "_period"}, period_out, 1000);
    check({tag, "_ready"}, cmd.cmd_ready, 1);
    check({tag, "_upd"}, upd_pulse, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_settled"}, settled, 1);
  endtask

`ifdef PWM_DUTY_RAMP_EN
  // Follows the ramp: +-1 steps toward the current target, tick-aligned spacing.
  task automatic track(input int stop_at, input int max_cyc);
    int  prev;
    int  d;
    int  gap;
    int  n;
    bit  fin;
    prev = int'(duty_cycle);
    gap  = -1;
    n    = 0;
    fin  = 1'b0;
    while (!fin && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
      if (gap >= 0) gap++;
      d = int'(duty_cycle);
      if (d != prev) begin
        check("ramp_step_size", (d - prev == 1 || prev - d == 1) ? 1 : 0, 1);
        check("ramp_direction", ((d > prev) == (cur_target > prev)) ? 1 : 0, 1);
        if (gap >= 0) check("ramp_gap", gap % RDIV, 0);
        $display("ramp: duty %0d -> %0d target=%0d", prev, d, cur_target);
        gap  = 0;
        prev = d;
      end
      check("settled_flag", settled, (d == cur_target) ? 1 : 0);
      if (stop_at >= 0) fin = (d == stop_at);
      else fin = (sb_q.size() == 0 && d == cur_target);
    end
    if (!fin) check("ramp_timeout", 0, 1);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd.cmd_valid   = 1'b0;
    cmd.cmd_period  = '0;
    cmd.cmd_percent = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

`ifndef PWM_DUTY_RAMP_EN
    send(16'd1000,  8'd25,  16'd250,   1'b1); wait_idle();
    send(16'd999,   8'd33,  16'd329,   1'b1); wait_idle();
    send(16'd65535, 8'd200, 16'd65535, 1'b1); wait_idle();
    send(16'd0,     8'd50,  16'd0,     1'b1); wait_idle();
    send(16'd100,   8'd100, 16'd100,   1'b1); wait_idle();
    send(16'd7,     8'd0,   16'd0,     1'b1); wait_idle();
    send(16'd40000, 8'd101, 16'd40000, 1'b1); wait_idle();
    send(16'd1234,  8'd1,   16'd12,    1'b1);
    send(16'd5000,  8'd99,  16'd4950,  1'b1); wait_idle();
    check("settled_tied", settled, 1);

    // A command offered mid-computation must be neither taken nor queued.
    send(16'd1000, 8'd25, 16'd250, 1'b1);
    repeat (3) @(negedge clk);
    cmd.cmd_valid   = 1'b1;
    cmd.cmd_period  = 16'd500;
    cmd.cmd_percent = 8'd80;
    repeat (3) @(negedge clk);
    check("ready_low_ignored_cmd", cmd.cmd_ready, 0);
    cmd.cmd_valid = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("hold_duty", duty_cycle, 250);
    check("hold_period", period_out, 1000);

    // Reset in flight: no update may ever appear for the aborted command.
    send(16'd2000, 8'd50, 16'd1000, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check_reset_vals("post_rst");
`else
    send(16'd100, 8'd0, 16'd0, 1'b1); wait_idle();
    check("ramp_start_duty", duty_cycle, 0);
    check("ramp_start_settled", settled, 1);
    send(16'd100, 8'd10, 16'd10, 1'b1);
    track(6, 300);
    send(16'd100, 8'd5, 16'd5, 1'b1);
    track(-1, 400);
    check("ramp_final_duty", duty_cycle, 5);
    check("ramp_final_settled", settled, 1);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_calc.md
# pwm_duty_calc

Command front-end that sits directly upstream of the PWM generator. It accepts a period and a duty percentage (0–100) over a valid/ready handshake and computes `duty_cycle = floor(period * percent / 100)` with a serial multiplier and a serial divider. It then drives the generator's `duty_cycle` and `period` inputs from registers. An optional build-time ramp makes duty changes fade in steps instead of jumping.

## Interface
- `RESET_PERIOD`, default 16'd1000: `period_out` value after reset.
- `RAMP_DIV`, default 256: clocks per ±1 duty step in ramp mode (≥1). Ignored without the macro.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: block can accept a command. High only in IDLE.
- `cmd_period`, input, 16: requested PWM period in clocks.
- `cmd_percent`, input, 8: requested duty in percent. Values above 100 clamp to 100.
- `duty_cycle`, output, 16: registered duty count sent to the PWM generator.
- `period_out`, output, 16: registered period sent to the PWM generator.
- `upd_pulse`, output, 1: one-cycle strobe when a new result is loaded.
- `busy`, output, 1: high in MUL, DIV and DONE.
- `settled`, output, 1: `duty_cycle` equals the computed target.

## Operation
- FSM states and transitions:
  - IDLE → MUL on `cmd_valid && cmd_ready`.
  - MUL → DIV after 8 cycles.
  - DIV → DONE after 23 cycles.
  - DONE → IDLE after 1 cycle.
- Accept: latch `cmd_period` and `min(cmd_percent, 100)`.
- Holding inputs stable is only required during the accepting cycle.
- MUL: shift-add, one percent bit per cycle, 23-bit product.
  - Maximum product is 65535 × 100 = 6 553 500, which is below 2^23.
- DIV: restoring division of the 23-bit product by constant 100, one quotient bit per cycle.
  - Quotient is truncated (floor) and always ≤ 65535, so it fits 16 bits.
  - Remainder is discarded.
- DONE:
  - `period_out` ← latched period.
  - Target ← quotient.
  - `upd_pulse` high.
- Arithmetic boundaries:
  - percent = 0 gives duty 0.
  - percent ≥ 100 gives duty = period.
  - period = 0 gives duty 0 and is passed through unchanged.
- `cmd_valid` during a busy phase is ignored: `cmd_ready` is low, and the command is neither lost-and-acknowledged nor queued.
- Reset mid-operation aborts the FSM to IDLE and discards the in-flight command.

## Timing
- Reset values:
  - `duty_cycle` = 0
  - `period_out` = `RESET_PERIOD`
  - `upd_pulse` = 0
  - `busy` = 0
  - `cmd_ready` = 1
  - `settled` = 1
  - FSM = IDLE, target = 0
- Latency: with the accepting edge as edge 0, the new `period_out` (and, without ramp, `duty_cycle`) is visible after edge 32.
  - `upd_pulse` is high in the same cycle the new values are visible.
- `cmd_ready` is low from edge 1 through edge 32 and high again after edge 32.
  - Sustained throughput is one command per 33 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PWM_DUTY_RAMP_EN` undefined:
  - `duty_cycle` ← quotient at DONE.
  - `settled` is tied to 1.
- `PWM_DUTY_RAMP_EN` defined:
  - At DONE, only the target is written, plus a clamp: `duty_cycle` ← min(`duty_cycle`, new period).
  - A free-running prescaler produces one tick every `RAMP_DIV` clocks.
  - On each tick, `duty_cycle` moves 1 toward the target.
  - `settled` = (`duty_cycle` == target).
  - A new command may arrive mid-ramp. It replaces the target, and the ramp continues from the current `duty_cycle` without a jump.

## Structure
- Shared package `pwm_pkg` holds:
  - Width constants: `PWM_W` = 16, `PCT_W` = 8, `PROD_W` = 23, `PCT_MAX` = 100.
  - FSM state encoding for IDLE, MUL, DIV, DONE.
- Sub-module `pwm_serial_div`: 23-bit restoring divider by a 7-bit constant, with start/done strobes, 23-cycle latency.
- Multiplier, FSM and ramp logic stay in the top level.

## Test plan
- Reset release → `duty_cycle` = 0, `period_out` = 1000, `cmd_ready` = 1, `upd_pulse` = 0.
- period = 1000, percent = 25 → after 32 cycles: `duty_cycle` = 250, `period_out` = 1000, one `upd_pulse`.
- period = 999, percent = 33 → `duty_cycle` = 329 (floor of 329.67).
- period = 65535, percent = 200 → clamped: `duty_cycle` = 65535.
- period = 0, percent = 50 → `duty_cycle` = 0.
- Second `cmd_valid` asserted on cycle 5 of a busy phase → ignored, first result unchanged; `rst_n` pulse at cycle 10 → outputs at reset values, no `upd_pulse`.
- With `PWM_DUTY_RAMP_EN` and `RAMP_DIV` = 4: 0 % → 10 % of period 100 → `duty_cycle` climbs 0 to 10 in steps every 4 clocks, then `settled` = 1.
  - A new command of 5 % at step 6 → `duty_cycle` reverses toward 5 from its current value.
